// File: rtl/regs_dbg_pkg.sv
// Shared widths, FSM encoding and timer sizing for the debug GPR access port.
package regs_dbg_pkg;

    localparam int          REG_BUS      = 32;
    localparam int          REG_ADDR_BUS = 5;
    localparam logic [31:0] ZERO_WORD    = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dbg_state_e;

    // The counter only ever needs to hold values up to HOLD_TIMEOUT-1.
    function automatic int timer_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/regs_dbg_hold_timer.sv
// Counts cycles spent waiting for the pipeline hold acknowledge; flags expiry.
module regs_dbg_hold_timer
    import regs_dbg_pkg::*;
#(
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = timer_width(HOLD_TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expired && (HOLD_TIMEOUT != 0)) begin
            count <= count + 1'b1;
        end
    end

    // A timeout of zero means wait forever, so the flag never rises.
    always_comb begin
        expired = (HOLD_TIMEOUT != 0) && (count == CW'(HOLD_TIMEOUT - 1));
    end

endmodule

// File: rtl/regs_dbg_port.sv
// Debug-side initiator for the GPR spare port: freeze pipeline, access GPR, respond.
// Optional REGS_DBG_STICKY_HOLD_EN keeps the pipeline frozen until dbg_resume_i.
module regs_dbg_port
    import regs_dbg_pkg::*;
#(
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dbg_req_i,
    input  logic                    dbg_we_i,
    input  logic [REG_ADDR_BUS-1:0] dbg_addr_i,
    input  logic [REG_BUS-1:0]      dbg_wdata_i,
    output logic                    dbg_gnt_o,
    output logic                    dbg_rvalid_o,
    output logic [REG_BUS-1:0]      dbg_rdata_o,
    output logic                    dbg_err_o,
    output logic                    hold_req_o,
    input  logic                    hold_ack_i,
    output logic                    rf_we_o,
    output logic [REG_ADDR_BUS-1:0] rf_waddr_o,
    output logic [REG_BUS-1:0]      rf_wdata_o,
    output logic                    rf_re_o,
    output logic [REG_ADDR_BUS-1:0] rf_raddr_o,
    input  logic [REG_BUS-1:0]      rf_rdata_i,
`ifdef REGS_DBG_STICKY_HOLD_EN
    input  logic                    dbg_resume_i,
`endif
    output dbg_state_e              fsm_state
);

    // Handshake: a request is taken on a cycle where dbg_req_i && dbg_gnt_o;
    // exactly one dbg_rvalid_o pulse answers it unless rst intervenes.
    dbg_state_e              state;
    logic                    cmd_we;
    logic [REG_ADDR_BUS-1:0] cmd_addr;
    logic [REG_BUS-1:0]      cmd_wdata;
    logic [REG_BUS-1:0]      resp_data;
    logic                    resp_err;
    logic                    accept;
    logic                    expired;
    logic                    sticky_hold;
    logic                    resume;
    logic                    direct;

    assign accept = dbg_req_i && (state == ST_IDLE);

    regs_dbg_hold_timer #(.HOLD_TIMEOUT(HOLD_TIMEOUT)) u_hold_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      ((state == ST_HOLD) && !hold_ack_i),
        .expired (expired)
    );

`ifdef REGS_DBG_STICKY_HOLD_EN
    assign resume = dbg_resume_i;

    // Only a successful access leaves the pipeline frozen; a timeout never got the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_hold <= 1'b0;
        end else if ((state == ST_RESP) && !resp_err) begin
            sticky_hold <= 1'b1;
        end else if ((state == ST_IDLE) && dbg_resume_i) begin
            sticky_hold <= 1'b0;
        end
    end
`else
    assign resume      = 1'b0;
    assign sticky_hold = 1'b0;
`endif

    assign direct = sticky_hold && !resume && hold_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= ZERO_WORD;
            resp_data <= ZERO_WORD;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dbg_req_i) begin
                        cmd_we    <= dbg_we_i;
                        cmd_addr  <= dbg_addr_i;
                        cmd_wdata <= dbg_wdata_i;
                        resp_data <= ZERO_WORD;
                        resp_err  <= 1'b0;
                        state     <= direct ? ST_ACCESS : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_ack_i) begin
                        state <= ST_ACCESS;
                    end else if (expired) begin
                        resp_err <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
                ST_ACCESS: begin
                    // x0 is hardwired to zero whatever the register file drives.
                    if (!cmd_we) begin
                        resp_data <= (cmd_addr == '0) ? ZERO_WORD : rf_rdata_i;
                    end
                    state <= ST_RESP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fsm_state    = state;
        dbg_gnt_o    = (state == ST_IDLE);
        hold_req_o   = (state != ST_IDLE) || sticky_hold;
        dbg_rvalid_o = (state == ST_RESP);
        dbg_rdata_o  = (state == ST_RESP) ? resp_data : ZERO_WORD;
        dbg_err_o    = (state == ST_RESP) && resp_err;
        rf_we_o      = (state == ST_ACCESS) && cmd_we && (cmd_addr != '0);
        rf_waddr_o   = ((state == ST_ACCESS) && cmd_we) ? cmd_addr : '0;
        rf_wdata_o   = ((state == ST_ACCESS) && cmd_we) ? cmd_wdata : ZERO_WORD;
        rf_re_o      = (state == ST_ACCESS) && !cmd_we;
        rf_raddr_o   = ((state == ST_ACCESS) && !cmd_we) ? cmd_addr : '0;
    end

endmodule

// File: tb/tb_regs_dbg_port.sv
// Bench for regs_dbg_port: GPR file model, reference register image, per-scenario tasks.
module tb_regs_dbg_port;
    import regs_dbg_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        hold_req, hold_ack;
    logic        rf_we, rf_re;
    logic [4:0]  rf_waddr, rf_raddr;
    logic [31:0] rf_wdata, rf_rdata;
    dbg_state_e  fsm_state;
`ifdef REGS_DBG_STICKY_HOLD_EN
    logic        dbg_resume;
`endif

    logic [31:0] rf_mem  [32];
    logic [31:0] exp_mem [32];
    logic [31:0] exp_q[$];
    logic        rf_init;
    bit          auto_resume = 1'b1;
    int          total = 0;
    int          bad = 0;

    int          mon_lat, mon_re_lat, mon_we_cnt, mon_re_cnt;
    logic [4:0]  mon_waddr;
    logic [31:0] mon_wdata, mon_rdata;
    logic        mon_err, mon_got;

    regs_dbg_port #(.HOLD_TIMEOUT(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .dbg_req_i    (dbg_req),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_gnt_o    (dbg_gnt),
        .dbg_rvalid_o (dbg_rvalid),
        .dbg_rdata_o  (dbg_rdata),
        .dbg_err_o    (dbg_err),
        .hold_req_o   (hold_req),
        .hold_ack_i   (hold_ack),
        .rf_we_o      (rf_we),
        .rf_waddr_o   (rf_waddr),
        .rf_wdata_o   (rf_wdata),
        .rf_re_o      (rf_re),
        .rf_raddr_o   (rf_raddr),
        .rf_rdata_i   (rf_rdata),
`ifdef REGS_DBG_STICKY_HOLD_EN
        .dbg_resume_i (dbg_resume),
`endif
        .fsm_state    (fsm_state)
    );

    // Clock and GPR file model (x0 holds garbage on purpose).
    always #5 clk = ~clk;

    assign rf_rdata = rf_mem[rf_raddr];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA5A5_0000 | i;
            rf_mem[0] <= 32'hBAD0_BAD0;
            rf_mem[5] <= 32'hDEAD_BEEF;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    // Driver: one transaction, ack rises ack_delay cycles into HOLD (<0: never).
    task automatic run_txn(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                           input int ack_delay);
        mon_lat = 0; mon_re_lat = -1; mon_we_cnt = 0; mon_re_cnt = 0;
        mon_got = 1'b0; mon_rdata = '0; mon_err = 1'b0; mon_waddr = '0; mon_wdata = '0;
        hold_ack  = (ack_delay == 0);
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wd;
        @(posedge clk); #1;
        dbg_req   = 1'b0;
        dbg_we    = 1'($urandom_range(1));
        dbg_addr  = 5'($urandom_range(31));
        dbg_wdata = $urandom;
        for (int c = 1; c <= 40 && !mon_got; c++) begin
            @(negedge clk);
            if (rf_we) begin
                mon_we_cnt++; mon_waddr = rf_waddr; mon_wdata = rf_wdata;
            end
            if (rf_re) begin
                mon_re_cnt++; mon_re_lat = c;
            end
            if (dbg_rvalid) begin
                mon_got = 1'b1; mon_lat = c; mon_rdata = dbg_rdata; mon_err = dbg_err;
            end
            @(posedge clk); #1;
            if (ack_delay >= 0 && c >= ack_delay) hold_ack = 1'b1;
        end
        total++;
        if (!mon_got) begin
            bad++; $display("FAIL rsp_timeout: got no rvalid, required one within 40 cycles");
        end
`ifdef REGS_DBG_STICKY_HOLD_EN
        if (auto_resume) begin
            dbg_resume = 1'b1;
            @(posedge clk); #1;
            dbg_resume = 1'b0;
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; rf_init = 1'b1; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0;
        dbg_wdata = '0; hold_ack = 1'b1;
`ifdef REGS_DBG_STICKY_HOLD_EN
        dbg_resume = 1'b0;
`endif
        for (int i = 0; i < 32; i++) exp_mem[i] = 32'hA5A5_0000 | i;
        exp_mem[0] = 32'h0;
        exp_mem[5] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({dbg_gnt, hold_req, dbg_rvalid, dbg_err, rf_we, rf_re} !== 6'b100000) begin
            bad++; $display("FAIL reset_ctl: got %b required 100000",
                            {dbg_gnt, hold_req, dbg_rvalid, dbg_err, rf_we, rf_re});
        end
        total++;
        if ({dbg_rdata, rf_waddr, rf_wdata, rf_raddr} !== 79'h0) begin
            bad++; $display("FAIL reset_data: got %h required 0",
                            {dbg_rdata, rf_waddr, rf_wdata, rf_raddr});
        end
        total++;
        if (fsm_state !== ST_IDLE) begin
            bad++; $display("FAIL reset_state: got %0d required %0d", fsm_state, ST_IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b0; rf_init = 1'b0;
    endtask

    task automatic test_read_x5();
        run_txn(1'b0, 5'd5, 32'h0, 0);
        total++;
        if (mon_lat !== 3) begin
            bad++; $display("FAIL read_lat: got %0d required 3", mon_lat);
        end
        total++;
        if (mon_re_lat !== 2 || mon_re_cnt !== 1 || mon_we_cnt !== 0) begin
            bad++; $display("FAIL read_strobe: got re_at=%0d re=%0d we=%0d required 2 1 0",
                            mon_re_lat, mon_re_cnt, mon_we_cnt);
        end
        total++;
        if ({mon_err, mon_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL read_x5: got err=%b data=%h required 0 deadbeef", mon_err, mon_rdata);
        end
    endtask

    task automatic test_write_x7();
        run_txn(1'b1, 5'd7, 32'h1234_5678, 0);
        exp_mem[7] = 32'h1234_5678;
        total++;
        if (mon_we_cnt !== 1 || mon_waddr !== 5'd7 || mon_wdata !== 32'h1234_5678) begin
            bad++; $display("FAIL write_x7: got we=%0d addr=%0d data=%h required 1 7 12345678",
                            mon_we_cnt, mon_waddr, mon_wdata);
        end
        total++;
        if (mon_lat !== 3 || mon_err !== 1'b0 || mon_rdata !== 32'h0) begin
            bad++; $display("FAIL write_rsp: got lat=%0d err=%b data=%h required 3 0 0",
                            mon_lat, mon_err, mon_rdata);
        end
        run_txn(1'b0, 5'd7, 32'h0, 0);
        total++;
        if (mon_rdata !== exp_mem[7]) begin
            bad++; $display("FAIL readback_x7: got %h required %h", mon_rdata, exp_mem[7]);
        end
    endtask

    task automatic test_write_x0();
        run_txn(1'b1, 5'd0, 32'hFFFF_FFFF, 0);
        total++;
        if (mon_we_cnt !== 0 || mon_err !== 1'b0 || mon_lat !== 3) begin
            bad++; $display("FAIL write_x0: got we=%0d err=%b lat=%0d required 0 0 3",
                            mon_we_cnt, mon_err, mon_lat);
        end
        run_txn(1'b0, 5'd0, 32'h0, 0);
        total++;
        if (mon_rdata !== 32'h0) begin
            bad++; $display("FAIL read_x0: got %h required 0", mon_rdata);
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 5'd3, 32'hCAFE_F00D, -1);
        total++;
        if (mon_err !== 1'b1 || mon_rdata !== 32'h0 || mon_lat !== T + 1) begin
            bad++; $display("FAIL timeout_rsp: got err=%b data=%h lat=%0d required 1 0 %0d",
                            mon_err, mon_rdata, mon_lat, T + 1);
        end
        total++;
        if (mon_we_cnt + mon_re_cnt !== 0) begin
            bad++; $display("FAIL timeout_strobe: got %0d rf strobes required 0",
                            mon_we_cnt + mon_re_cnt);
        end
        @(negedge clk);
        total++;
        if (hold_req !== 1'b0 || dbg_gnt !== 1'b1) begin
            bad++; $display("FAIL timeout_release: got hold=%b gnt=%b required 0 1", hold_req, dbg_gnt);
        end
        @(posedge clk); #1;
        hold_ack = 1'b1;
    endtask

    task automatic test_rst_mid();
        int events;
        hold_ack = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = $urandom;
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_gnt !== 1'b1 || hold_req !== 1'b0 || fsm_state !== ST_IDLE) begin
            bad++; $display("FAIL rst_mid: got gnt=%b hold=%b state=%0d required 1 0 0",
                            dbg_gnt, hold_req, fsm_state);
        end
        hold_ack = 1'b1;
        events = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dbg_rvalid || rf_we) events++;
        end
        total++;
        if (events !== 0) begin
            bad++; $display("FAIL rst_mid_quiet: got %0d rvalid/we cycles required 0", events);
        end
        @(posedge clk); #1;
        run_txn(1'b0, 5'd9, 32'h0, 0);
        total++;
        if (mon_rdata !== exp_mem[9]) begin
            bad++; $display("FAIL rst_mid_x9: got %h required %h", mon_rdata, exp_mem[9]);
        end
    endtask

    // Back-to-back random traffic against the reference register image.
    task automatic test_random();
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        int          d;
        for (int n = 0; n < 30; n++) begin
            we   = 1'($urandom_range(1));
            addr = 5'($urandom_range(31));
            wd   = $urandom;
            d    = $urandom_range(2);
            if (!we) exp_q.push_back(exp_mem[addr]);
            run_txn(we, addr, wd, d);
            total++;
            if (mon_lat !== 3 + d || mon_err !== 1'b0) begin
                bad++; $display("FAIL rand_lat[%0d]: got lat=%0d err=%b required %0d 0",
                                n, mon_lat, mon_err, 3 + d);
            end
            if (we) begin
                total++;
                if (mon_we_cnt !== int'(addr != 0) ||
                    (addr != 0 && (mon_waddr !== addr || mon_wdata !== wd))) begin
                    bad++; $display("FAIL rand_wr[%0d]: got we=%0d addr=%0d data=%h required addr=%0d data=%h",
                                    n, mon_we_cnt, mon_waddr, mon_wdata, addr, wd);
                end
                if (addr != 0) exp_mem[addr] = wd;
            end else begin
                total++;
                if (mon_rdata !== exp_q[0]) begin
                    bad++; $display("FAIL rand_rd[%0d]: got %h required %h x%0d",
                                    n, mon_rdata, exp_q[0], addr);
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

`ifdef REGS_DBG_STICKY_HOLD_EN
    task automatic test_sticky();
        auto_resume = 1'b0;
        run_txn(1'b0, 5'd5, 32'h0, 0);
        total++;
        if (mon_lat !== 3) begin
            bad++; $display("FAIL sticky_first: got lat=%0d required 3", mon_lat);
        end
        @(negedge clk);
        total++;
        if (hold_req !== 1'b1 || dbg_gnt !== 1'b1) begin
            bad++; $display("FAIL sticky_held: got hold=%b gnt=%b required 1 1", hold_req, dbg_gnt);
        end
        @(posedge clk); #1;
        run_txn(1'b0, 5'd7, 32'h0, 0);
        total++;
        if (mon_lat !== 2 || mon_re_lat !== 1 || mon_rdata !== exp_mem[7]) begin
            bad++; $display("FAIL sticky_second: got lat=%0d re_at=%0d data=%h required 2 1 %h",
                            mon_lat, mon_re_lat, mon_rdata, exp_mem[7]);
        end
        dbg_resume = 1'b1;
        @(posedge clk); #1;
        dbg_resume = 1'b0;
        @(negedge clk);
        total++;
        if (hold_req !== 1'b0) begin
            bad++; $display("FAIL sticky_resume: got hold=%b required 0", hold_req);
        end
        @(posedge clk); #1;
        auto_resume = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_read_x5();
        test_write_x7();
        test_write_x0();
        test_timeout();
        test_rst_mid();
        test_random();
`ifdef REGS_DBG_STICKY_HOLD_EN
        test_sticky();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
